// File: rtl/alu_div_pkg.sv
// Shared types and constants for the divide sequencing stage in front of the 6x3 array divider.
package alu_div_pkg;

    localparam int unsigned DVD_W_DEF = 6;
    localparam int unsigned DVS_W_DEF = 3;
    localparam int unsigned CNT_W     = 4;

    // Quotient reported for a divide-by-zero request.
    localparam logic [DVD_W_DEF-1:0] DIV0_Q = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/alu_div_ctrl.sv
// Sequences requests through the external combinational divider as a multicycle path.
// Optional macro ALU_DIV_BACK2BACK_EN lets a new request be accepted in the response handshake cycle.
module alu_div_ctrl
    import alu_div_pkg::*;
#(
    parameter int unsigned DVD_W  = DVD_W_DEF,
    parameter int unsigned DVS_W  = DVS_W_DEF,
    parameter int unsigned SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [DVD_W-1:0] req_dividend,
    input  logic [DVS_W-1:0] req_divisor,
    output logic [DVD_W-1:0] dv_dividend,
    output logic [DVS_W-1:0] dv_divisor,
    input  logic [DVD_W-1:0] dv_q,
    input  logic [DVS_W-1:0] dv_r,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DVD_W-1:0] rsp_q,
    output logic [DVS_W-1:0] rsp_r,
    output logic             rsp_err,
    output logic             busy
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DVD_W-1:0]   dv_dividend_q, dv_dividend_d;
    logic [DVS_W-1:0]   dv_divisor_q, dv_divisor_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DVD_W-1:0]   rsp_quot_q, rsp_quot_d;
    logic [DVS_W-1:0]   rsp_rem_q, rsp_rem_d;
    logic               rsp_err_q, rsp_err_d;
    logic               req_ready_c;
    logic               req_acc_c;
    logic               rsp_hs_c;

    // Request acceptance window.
    always_comb begin
        req_ready_c = (state_q == ST_IDLE);
`ifdef ALU_DIV_BACK2BACK_EN
        if (state_q == ST_RESP) begin
            req_ready_c = rsp_ready;
        end
`endif
        req_acc_c = req_valid && req_ready_c;
        rsp_hs_c  = (state_q == ST_RESP) && rsp_ready;
    end

    // Next-state and datapath update.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        dv_dividend_d = dv_dividend_q;
        dv_divisor_d  = dv_divisor_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_quot_d    = rsp_quot_q;
        rsp_rem_d     = rsp_rem_q;
        rsp_err_d     = rsp_err_q;

        case (state_q)
            ST_IDLE: ;
            ST_SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    rsp_quot_d  = dv_q;
                    rsp_rem_d   = dv_r;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_hs_c) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Acceptance overrides the RESP retirement when both happen on one edge.
        if (req_acc_c) begin
            dv_dividend_d = req_dividend;
            dv_divisor_d  = req_divisor;
            if (req_divisor == '0) begin
                rsp_quot_d  = DVD_W'(DIV0_Q);
                rsp_rem_d   = '0;
                rsp_err_d   = 1'b1;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end else begin
                cnt_d       = CNT_W'(SETTLE - 1);
                rsp_valid_d = 1'b0;
                state_d     = ST_SETTLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            dv_dividend_q <= '0;
            dv_divisor_q  <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_quot_q    <= '0;
            rsp_rem_q     <= '0;
            rsp_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dv_dividend_q <= dv_dividend_d;
            dv_divisor_q  <= dv_divisor_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_quot_q    <= rsp_quot_d;
            rsp_rem_q     <= rsp_rem_d;
            rsp_err_q     <= rsp_err_d;
        end
    end

    assign req_ready   = req_ready_c;
    assign dv_dividend = dv_dividend_q;
    assign dv_divisor  = dv_divisor_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_q       = rsp_quot_q;
    assign rsp_r       = rsp_rem_q;
    assign rsp_err     = rsp_err_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_div_ctrl.sv
// Bench for alu_div_ctrl: directed and random divides against an arithmetic reference model.
// Also covers ALU_DIV_BACK2BACK_EN when the macro is defined for the build.
module tb_alu_div_ctrl;

    localparam int unsigned DVD_W  = 6;
    localparam int unsigned DVS_W  = 3;
    localparam int unsigned SETTLE = 2;
    localparam int          MAX_WAIT = 20;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [DVD_W-1:0] req_dividend;
    logic [DVS_W-1:0] req_divisor;
    logic [DVD_W-1:0] dv_dividend;
    logic [DVS_W-1:0] dv_divisor;
    logic [DVD_W-1:0] dv_q;
    logic [DVS_W-1:0] dv_r;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [DVD_W-1:0] rsp_q;
    logic [DVS_W-1:0] rsp_r;
    logic             rsp_err;
    logic             busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Stand-in for the combinational array divider.
    assign dv_q = (dv_divisor == '0) ? '1 : DVD_W'(dv_dividend / dv_divisor);
    assign dv_r = (dv_divisor == '0) ? '0 : DVS_W'(dv_dividend % dv_divisor);

    alu_div_ctrl #(
        .DVD_W  (DVD_W),
        .DVS_W  (DVS_W),
        .SETTLE (SETTLE)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .dv_dividend  (dv_dividend),
        .dv_divisor   (dv_divisor),
        .dv_q         (dv_q),
        .dv_r         (dv_r),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_q        (rsp_q),
        .rsp_r        (rsp_r),
        .rsp_err      (rsp_err),
        .busy         (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: result triple and edges from accept until rsp_valid is visible.
    task automatic ref_model(input int a, input int b, output int q, output int r, output int e,
                             output int lat);
        if (b == 0) begin
            q = (1 << DVD_W) - 1; r = 0; e = 1; lat = 0;
        end else begin
            q = a / b; r = a % b; e = 0; lat = int'(SETTLE);
        end
    endtask

    // Called at a negedge; returns how many further negedges pass until rsp_valid is seen.
    task automatic wait_rsp(input int a, input int b, input bit poke, output int k);
        k = 0;
        while (rsp_valid !== 1'b1 && k < MAX_WAIT) begin
            check_eq("busy_wait", 32'(busy), 32'd1);
            check_eq("rdy_wait", 32'(req_ready), 32'd0);
            req_valid    = poke;
            req_dividend = DVD_W'($urandom);
            req_divisor  = DVS_W'($urandom);
            @(negedge clk);
            k++;
            check_eq("dv_dvd_stable", 32'(dv_dividend), 32'(a));
            check_eq("dv_dvs_stable", 32'(dv_divisor), 32'(b));
        end
        req_valid = 1'b0;
    endtask

    task automatic check_rsp(input string tag, input int q, input int r, input int e);
        check_eq({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check_eq({tag, "_q"}, 32'(rsp_q), 32'(q));
        check_eq({tag, "_r"}, 32'(rsp_r), 32'(r));
        check_eq({tag, "_err"}, 32'(rsp_err), 32'(e));
    endtask

    // One full transaction starting at a negedge with the controller idle.
    task automatic run_txn(input int a, input int b, input int hold, input bit poke);
        int q, r, e, lat, k;
        ref_model(a, b, q, r, e, lat);
        check_eq("rdy_idle", 32'(req_ready), 32'd1);
        check_eq("busy_idle", 32'(busy), 32'd0);
        req_valid    = 1'b1;
        req_dividend = DVD_W'(a);
        req_divisor  = DVS_W'(b);
        rsp_ready    = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("dv_dvd_latch", 32'(dv_dividend), 32'(a));
        check_eq("dv_dvs_latch", 32'(dv_divisor), 32'(b));
        wait_rsp(a, b, poke, k);
        check_eq("latency", 32'(k), 32'(lat));
        check_rsp("rsp", q, r, e);
        for (int i = 0; i < hold; i++) begin
            check_eq("rdy_hold", 32'(req_ready), 32'd0);
            req_valid    = poke;
            req_dividend = DVD_W'($urandom);
            req_divisor  = DVS_W'($urandom);
            @(negedge clk);
            check_rsp("hold", q, r, e);
            check_eq("dv_dvd_hold", 32'(dv_dividend), 32'(a));
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
`ifndef ALU_DIV_BACK2BACK_EN
        check_eq("rdy_resp", 32'(req_ready), 32'd0);
`endif
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("valid_after_hs", 32'(rsp_valid), 32'd0);
        check_eq("busy_after_hs", 32'(busy), 32'd0);
    endtask

`ifdef ALU_DIV_BACK2BACK_EN
    // First request answered, second offered in the handshake cycle of the first.
    task automatic run_b2b(input int a0, input int b0, input int a1, input int b1);
        int q, r, e, lat, k;
        ref_model(a0, b0, q, r, e, lat);
        req_valid = 1'b1; req_dividend = DVD_W'(a0); req_divisor = DVS_W'(b0);
        @(negedge clk);
        req_valid = 1'b0;
        wait_rsp(a0, b0, 1'b0, k);
        check_eq("b2b_lat0", 32'(k), 32'(lat));
        check_rsp("b2b_rsp0", q, r, e);
        ref_model(a1, b1, q, r, e, lat);
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_dividend = DVD_W'(a1); req_divisor = DVS_W'(b1);
        check_eq("b2b_rdy", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        check_eq("b2b_busy", 32'(busy), 32'd1);
        check_eq("b2b_dvd", 32'(dv_dividend), 32'(a1));
        wait_rsp(a1, b1, 1'b0, k);
        check_eq("b2b_lat1", 32'(k), 32'(lat));
        check_rsp("b2b_rsp1", q, r, e);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("b2b_done", 32'(rsp_valid), 32'd0);
    endtask
`endif

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_dividend = '0;
        req_divisor  = '0;
        rsp_ready    = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_q", 32'(rsp_q), 32'd0);
        check_eq("rst_r", 32'(rsp_r), 32'd0);
        check_eq("rst_err", 32'(rsp_err), 32'd0);
        check_eq("rst_dvd", 32'(dv_dividend), 32'd0);
        check_eq("rst_dvs", 32'(dv_divisor), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rdy", 32'(req_ready), 32'd1);

        run_txn(13, 3, 0, 1'b0);
        run_txn(63, 7, 0, 1'b1);
        run_txn(0, 5, 1, 1'b0);
        run_txn(22, 0, 0, 1'b0);
        run_txn(45, 4, 5, 1'b1);
        run_txn(63, 1, 0, 1'b0);
        run_txn(0, 0, 2, 1'b1);

        // Reset in the middle of the settle window discards the request.
        req_valid = 1'b1; req_dividend = DVD_W'(50); req_divisor = DVS_W'(6);
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("midrst_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_rdy", 32'(req_ready), 32'd1);
        check_eq("midrst_dvd", 32'(dv_dividend), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("midrst_novalid", 32'(rsp_valid), 32'd0);
        end

        for (int n = 0; n < 40; n++) begin
            int a, b;
            a = int'($urandom_range(0, 63));
            b = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 7));
            run_txn(a, b, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

`ifdef ALU_DIV_BACK2BACK_EN
        run_b2b(13, 3, 30, 4);
        run_b2b(17, 5, 22, 0);
        run_b2b(9, 0, 40, 6);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
